writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width.
REQ-002 SHALL have parameter PEND_DEPTH, default 4: maximum outstanding loads (power of two).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports alu_valid/alu_ready  input/output  1/1  ALU result handshake; alu_rd input 5, alu_data input XLEN.
REQ-006 SHALL have ports ld_issue/ld_issue_ready  input/output  1/1  load issue handshake; ld_rd input 5, the load's destination.
REQ-007 SHALL have ports ld_resp_valid/ld_resp_ready  input/output  1/1  in-order load data return; ld_resp_data input XLEN.
REQ-008 SHALL have ports w_en output 1, w_addr output 5, w_data output XLEN: register-file write port, all registered.
REQ-009 SHALL have ports q_addr_0/q_addr_1 input 5 and q_busy_0/q_busy_1 output 1: scoreboard query for decode.

Function
REQ-010 SHALL keep a pending-rd queue (PEND_DEPTH entries); ld_issue && ld_issue_ready pushes ld_rd.
REQ-011 SHALL drive ld_issue_ready = queue not full AND busy[ld_rd]==0 (combinational on ld_rd; x0 never busy).
REQ-012 SHALL set busy[ld_rd] on issue acceptance when ld_rd != 0; x0 loads occupy a queue entry but never set busy.
REQ-013 SHALL drive ld_resp_ready = pending queue non-empty AND skid buffer (2 entries) not full.
REQ-014 SHALL, on ld_resp_valid && ld_resp_ready, pop the queue head rd and push {rd, ld_resp_data} into the skid buffer same edge.
REQ-015 SHALL drive alu_ready = skid buffer not full (count < 2).
REQ-016 SHALL arbitrate per cycle: accepted ALU result wins; else skid-buffer head is written and popped.
REQ-017 SHALL register the selected write: w_en/w_addr/w_data valid the cycle after selection (latency 1 from ALU handshake, min 2 from load response).
REQ-018 SHALL force w_en=0 for rd==0 from either source; the entry is still consumed.
REQ-019 SHALL clear busy[rd] on the edge the load write is registered; a same-cycle ld_issue to that rd is still refused (busy sampled pre-edge).
REQ-020 SHALL perform an ALU write to a busy register unchanged and leave busy set (later load overwrites).
REQ-021 SHALL compute q_busy_n = busy[q_addr_n] combinationally; x0 returns 0.
REQ-022 SHALL allow simultaneous issue, response and ALU acceptance in one cycle with all three effects applied.
REQ-023 SHALL guarantee load writes retire in issue order; ld_resp_valid with empty queue is ignored (ready=0).

Reset
REQ-024 SHALL, while rst_n=0, immediately clear w_en, w_addr, w_data, all busy bits, queue and skid pointers/counts.
REQ-025 SHALL present after reset: alu_ready=1, ld_issue_ready=1, ld_resp_ready=0, q_busy_*=0.
REQ-026 SHALL discard outstanding loads on reset mid-operation; no write follows reset deassertion until new traffic.

Structure
REQ-027 SHALL place XLEN, REG_ADDR_W=5 and the skid entry struct {rd, data} in shared package wb_pkg.
REQ-028 SHALL instantiate one generic sub-module wb_fifo (parameterised width/depth, full/empty/count) twice: pending queue and skid buffer.
REQ-029 SHALL contain no combinational path from ld_resp_data or alu_data to any output.

Verification
REQ-030 SHALL test: alu_valid, rd=5, data=0xDEADBEEF -> next cycle w_en=1, w_addr=5, w_data=0xDEADBEEF.
REQ-031 SHALL test: issue loads rd=3,7; responses 0x11,0x22 -> writes rd3=0x11 then rd7=0x22; busy[3],busy[7] clear after each write.
REQ-032 SHALL test: issue 4 loads -> ld_issue_ready=0; issue again rd already busy -> refused; after one response ready returns.
REQ-033 SHALL test: continuous alu_valid while 2 load responses arrive -> skid fills, alu_ready=0 one cycle, loads drain, no write lost.
REQ-034 SHALL test: ALU and load both with rd=0 -> w_en never asserts; queue drains; q_busy for x0 stays 0.
REQ-035 SHALL test: rst_n low with 3 loads pending -> busy all 0, ld_resp_ready=0, w_en=0 immediately and after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the skid-buffer entry layout for the writeback path.
package wb_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } skid_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO (power-of-two depth, >= 2) with full/empty/count flags.
module wb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback: ALU results and in-order load returns, with a load scoreboard.
// Skid entries use wb_pkg::skid_entry_t, so XLEN must equal wb_pkg::XLEN.
module writeback_unit #(
   parameter int XLEN       = wb_pkg::XLEN,
   parameter int PEND_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        alu_valid,
   output logic                        alu_ready,
   input  logic [wb_pkg::REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]             alu_data,
   input  logic                        ld_issue,
   output logic                        ld_issue_ready,
   input  logic [wb_pkg::REG_ADDR_W-1:0] ld_rd,
   input  logic                        ld_resp_valid,
   output logic                        ld_resp_ready,
   input  logic [XLEN-1:0]             ld_resp_data,
   output logic                        w_en,
   output logic [wb_pkg::REG_ADDR_W-1:0] w_addr,
   output logic [XLEN-1:0]             w_data,
   input  logic [wb_pkg::REG_ADDR_W-1:0] q_addr_0,
   input  logic [wb_pkg::REG_ADDR_W-1:0] q_addr_1,
   output logic                        q_busy_0,
   output logic                        q_busy_1
);

   import wb_pkg::*;

   localparam int NREG  = 2 ** REG_ADDR_W;
   localparam int PCW   = $clog2(PEND_DEPTH + 1);
   localparam int SKIDN = 2;
   localparam int SCW   = $clog2(SKIDN + 1);

   logic [NREG-1:0]       busy;
   logic [NREG-1:0]       busy_nxt;
   logic                  pend_full;
   logic                  pend_empty;
   logic [PCW-1:0]        pend_count_unused;
   logic [REG_ADDR_W-1:0] pend_head;
   logic                  skid_full;
   logic                  skid_empty;
   logic [SCW-1:0]        skid_count;
   skid_entry_t           skid_in;
   skid_entry_t           skid_head;
   logic                  issue_fire;
   logic                  resp_fire;
   logic                  alu_fire;
   logic                  skid_pop;
   logic                  sel_valid;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;

   // Handshakes depend only on state and addresses, never on data inputs.
   assign alu_ready      = (skid_count < SCW'(SKIDN));
   assign ld_issue_ready = !pend_full && !busy[ld_rd];
   assign ld_resp_ready  = !pend_empty && !skid_full;
   assign q_busy_0       = busy[q_addr_0];
   assign q_busy_1       = busy[q_addr_1];

   assign issue_fire = ld_issue && ld_issue_ready;
   assign resp_fire  = ld_resp_valid && ld_resp_ready;
   assign alu_fire   = alu_valid && alu_ready;
   assign skid_pop   = !alu_fire && !skid_empty;

   assign skid_in.rd   = pend_head;
   assign skid_in.data = ld_resp_data;

   wb_fifo #(
      .WIDTH (REG_ADDR_W),
      .DEPTH (PEND_DEPTH)
   ) u_pend_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (issue_fire),
      .push_data (ld_rd),
      .pop       (resp_fire),
      .pop_data  (pend_head),
      .full      (pend_full),
      .empty     (pend_empty),
      .count     (pend_count_unused)
   );

   wb_fifo #(
      .WIDTH ($bits(skid_entry_t)),
      .DEPTH (SKIDN)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (resp_fire),
      .push_data (skid_in),
      .pop       (skid_pop),
      .pop_data  (skid_head),
      .full      (skid_full),
      .empty     (skid_empty),
      .count     (skid_count)
   );

   // ALU wins arbitration; otherwise the oldest returned load retires.
   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      if (alu_fire) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end else if (skid_pop) begin
         sel_valid = 1'b1;
         sel_rd    = skid_head.rd;
         sel_data  = skid_head.data;
      end
   end

   // Clear precedes set; a busy rd can never be re-issued, so they never collide.
   always_comb begin
      busy_nxt = busy;
      if (skid_pop) busy_nxt[skid_head.rd] = 1'b0;
      if (issue_fire) busy_nxt[ld_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= '0;
         w_en   <= 1'b0;
         w_addr <= '0;
         w_data <= '0;
      end else begin
         busy <= busy_nxt;
         w_en <= sel_valid && (sel_rd != '0);
         if (sel_valid) begin
            w_addr <= sel_rd;
            w_data <= sel_data;
         end
      end
   end

endmodule
